mdu_iter: RTL and testbench

Iterative RV32M/RV64M multiply–divide unit, parametrised in XLEN. It is the sequential companion to the ALU decoder and sits in the execute stage beside the ALU. It is selected when the decoded R-type instruction carries funct7 = 0000001. It decodes funct3 into the eight M-extension operations, runs them over multiple cycles with a start/busy/valid handshake, and resolves the RISC-V divide corner cases without iterating.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_opdec.sv | 24 ++
 rtl/mdu_iter.sv | 187 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, FSM states and decoded-op struct for the M-extension unit
package mdu_pkg;

   localparam logic [2:0] MDU_MUL    = 3'b000;
   localparam logic [2:0] MDU_MULH   = 3'b001;
   localparam logic [2:0] MDU_MULHSU = 3'b010;
   localparam logic [2:0] MDU_MULHU  = 3'b011;
   localparam logic [2:0] MDU_DIV    = 3'b100;
   localparam logic [2:0] MDU_DIVU   = 3'b101;
   localparam logic [2:0] MDU_REM    = 3'b110;
   localparam logic [2:0] MDU_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN
   } mdu_state_t;

   typedef struct packed {
      logic is_div;
      logic is_rem;
      logic a_signed;
      logic b_signed;
      logic high;
   } mdu_op_t;

endpackage

// File: rtl/mdu_opdec.sv
// rtl/mdu_opdec.sv - funct3 to decoded M-op; also used by the hazard unit to predict latency
module mdu_opdec
   import mdu_pkg::*;
(
   input  logic [2:0] funct3,
   output mdu_op_t    op
);

   always_comb begin
      op = '0;
      case (funct3)
         MDU_MUL:    op = '0;
         MDU_MULH:   begin op.a_signed = 1'b1; op.b_signed = 1'b1; op.high = 1'b1; end
         MDU_MULHSU: begin op.a_signed = 1'b1; op.high = 1'b1; end
         MDU_MULHU:  op.high = 1'b1;
         MDU_DIV:    begin op.is_div = 1'b1; op.a_signed = 1'b1; op.b_signed = 1'b1; end
         MDU_DIVU:   op.is_div = 1'b1;
         MDU_REM:    begin op.is_div = 1'b1; op.is_rem = 1'b1; op.a_signed = 1'b1; op.b_signed = 1'b1; end
         MDU_REMU:   begin op.is_div = 1'b1; op.is_rem = 1'b1; end
         default:    op = '0;
      endcase
   end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M/RV64M multiply-divide unit (start/busy/valid handshake)
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply instead of shift-add iteration.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            valid,
   output logic [XLEN-1:0] result
);

   localparam int              CW       = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_t        state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   mdu_op_t           op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic              neg_q, neg_d;
   logic              spec_q, spec_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN:0]     rem_q, rem_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic [XLEN-1:0]   result_q, result_d;

   mdu_op_t         dec_op;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf;
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic            div_ge;
   logic [2*XLEN-1:0] fin_val, fin_signed;

   mdu_opdec u_opdec (
      .funct3 (funct3),
      .op     (dec_op)
   );

   always_comb begin
      a_neg    = dec_op.a_signed & rs1[XLEN-1];
      b_neg    = dec_op.b_signed & rs2[XLEN-1];
      a_mag    = a_neg ? -rs1 : rs1;
      b_mag    = b_neg ? -rs2 : rs2;
      div_zero = (rs2 == '0);
      div_ovf  = dec_op.a_signed && (rs1 == MIN_NEG) && (rs2 == {XLEN{1'b1}});

      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
      div_shift = {rem_q[XLEN-1:0], a_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, b_q};
      // Partial remainder stays below the divisor, so the borrow bit alone decides the step.
      div_ge    = ~div_diff[XLEN];

      if (spec_q || !op_q.is_div)
         fin_val = acc_q;
      else if (op_q.is_rem)
         fin_val = {{XLEN{1'b0}}, rem_q[XLEN-1:0]};
      else
         fin_val = {{XLEN{1'b0}}, a_q};
      fin_signed = neg_q ? -fin_val : fin_val;
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      neg_d    = neg_q;
      spec_d   = spec_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;
      result_d = result_q;

      if (flush) begin
         state_d = IDLE;
         count_d = '0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_d    = dec_op;
                  a_d     = a_mag;
                  b_d     = b_mag;
                  neg_d   = a_neg ^ (b_neg & ~dec_op.is_rem);
                  spec_d  = 1'b0;
                  acc_d   = '0;
                  rem_d   = '0;
                  count_d = '0;
                  busy_d  = 1'b1;
                  state_d = CALC;
                  if (dec_op.is_div && div_zero) begin
                     spec_d  = 1'b1;
                     neg_d   = 1'b0;
                     acc_d   = {{XLEN{1'b0}}, (dec_op.is_rem ? rs1 : {XLEN{1'b1}})};
                     state_d = FIN;
                  end else if (dec_op.is_div && div_ovf) begin
                     spec_d  = 1'b1;
                     neg_d   = 1'b0;
                     acc_d   = {{XLEN{1'b0}}, (dec_op.is_rem ? {XLEN{1'b0}} : rs1)};
                     state_d = FIN;
                  end
`ifdef MDU_FAST_MUL_EN
                  else if (!dec_op.is_div) begin
                     acc_d   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
                     state_d = FIN;
                  end
`endif
               end
            end
            CALC: begin
               if (op_q.is_div) begin
                  rem_d = div_ge ? div_diff : div_shift;
                  a_d   = {a_q[XLEN-2:0], div_ge};
               end else begin
                  acc_d = {mul_sum, acc_q[XLEN-1:1]};
                  b_d   = b_q >> 1;
               end
               if (count_q == CNT_LAST) begin
                  count_d = '0;
                  state_d = FIN;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
            FIN: begin
               result_d = op_q.high ? fin_signed[2*XLEN-1:XLEN] : fin_signed[XLEN-1:0];
               valid_d  = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         neg_q    <= 1'b0;
         spec_q   <= 1'b0;
         acc_q    <= '0;
         rem_q    <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
         spec_q   <= spec_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         result_q <= result_d;
      end
   end

   assign busy   = busy_q;
   assign valid  = valid_q;
   assign result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter at XLEN=32
module tb_mdu_iter;
   import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        busy;
   logic        valid;
   logic [31:0] result;

   int tests;
   int fails;
   int cyc;
   logic saw_valid;

   mdu_iter #(.XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .rs1    (rs1),
      .rs2    (rs2),
      .busy   (busy),
      .valid  (valid),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in cycle 0; returns at the negedge of the cycle after valid.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      start  = 1'b1;
      funct3 = f;
      rs1    = a;
      rs2    = b;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      check({tag, "_busy1"}, {31'b0, busy}, 32'd1);
      while (!valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_res"}, result, exp);
      check({tag, "_busy_at_valid"}, {31'b0, busy}, 32'd0);
      @(negedge clk);
      check({tag, "_single_valid"}, {31'b0, valid}, 32'd0);
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = '0;
      rs1    = '0;
      rs2    = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_valid", {31'b0, valid}, 32'd0);
      check("reset_result", result, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("div_neg7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      run_op("rem_neg7_2", MDU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      run_op("divu_by0", MDU_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 2);
      run_op("rem_by0", MDU_REM, 32'd5, 32'd0, 32'h0000_0005, 2);
      run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      run_op("rem_ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
      run_op("mul", MDU_MUL, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, MUL_LAT);
      run_op("mulh", MDU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
      run_op("mulhsu", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);

      // Divide started in cycle 0, stray start in cycle 5, flush in cycle 10.
      start  = 1'b1;
      funct3 = MDU_DIV;
      rs1    = 32'd1000;
      rs2    = 32'd3;
      @(negedge clk);
      start     = 1'b0;
      cyc       = 1;
      saw_valid = valid;
      while (cyc < 5) begin
         @(negedge clk);
         cyc++;
         saw_valid |= valid;
      end
      start  = 1'b1;
      funct3 = MDU_MUL;
      rs1    = 32'd3;
      rs2    = 32'd3;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      saw_valid |= valid;
      check("ignored_start_busy", {31'b0, busy}, 32'd1);
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
         saw_valid |= valid;
      end
      flush = 1'b1;
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 32'd0);
      check("flush_no_valid", {31'b0, saw_valid | valid}, 32'd0);
      check("flush_result_held", result, 32'hFFFF_FFFF);
      run_op("divu_after_flush", MDU_DIVU, 32'd100, 32'd7, 32'h0000_000E, 34);

      // Reset in cycle 20 of a divide.
      start  = 1'b1;
      funct3 = MDU_DIV;
      rs1    = 32'd1000;
      rs2    = 32'd3;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("pre_reset_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midop_reset_busy", {31'b0, busy}, 32'd0);
      check("midop_reset_valid", {31'b0, valid}, 32'd0);
      check("midop_reset_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("mulhu", MDU_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, MUL_LAT);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
